speed_step_ctrl: RTL and testbench

SPEED_STEP_CTRL -- requirements
Module: speed_step_ctrl

---
 rtl/speed_step_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_speed_step_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/speed_step_ctrl.sv
// Two-button speed stepper: synchronizes and debounces the raw buttons, then issues single
// and auto-repeating step pulses while tracking the resulting divider level.
module speed_step_ctrl #(
    parameter int unsigned DEB_MS     = 20,
    parameter int unsigned RPT_DLY_MS = 500,
    parameter int unsigned RPT_MS     = 100,
    parameter int unsigned LVL_MIN    = 9,
    parameter int unsigned LVL_MAX    = 26,
    parameter int unsigned LVL_RST    = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m_f,
    input  logic [1:0] btn_raw,
    output logic [1:0] step,
    output logic [4:0] level,
    output logic       at_min,
    output logic       at_max
);

    localparam int unsigned MaxA = (DEB_MS > RPT_DLY_MS) ? DEB_MS : RPT_DLY_MS;
    localparam int unsigned MaxP = (MaxA > RPT_MS) ? MaxA : RPT_MS;
    localparam int unsigned CntW = $clog2(MaxP + 2);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t DebLim = cnt_t'(DEB_MS);
    localparam cnt_t DlyLim = cnt_t'(RPT_DLY_MS);
    localparam cnt_t RptLim = cnt_t'(RPT_MS);

    localparam logic [4:0] LvlMin = 5'(LVL_MIN);
    localparam logic [4:0] LvlMax = 5'(LVL_MAX);
    localparam logic [4:0] LvlRst = 5'(LVL_RST);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat, StLock} state_e;

    // Counters hold at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d;
    logic [1:0]            stable_prev_q;
    logic [1:0][CntW-1:0]  deb_cnt_q, deb_cnt_d;

    state_e                state_q, state_d;
    logic [1:0]            act_q, act_d;
    cnt_t                  tick_q, tick_d;
    cnt_t                  tick_inc;
    logic [1:0]            rise;
    logic                  fire;

    logic [1:0]            step_q, step_d;
    logic [4:0]            level_q, level_d;
    logic                  at_min_q, at_max_q;

    // ---------------------------------------------------------------------------------------
    // Input synchronizer
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Debounce: stable follows the synced value only after DEB_MS consecutive differing ticks
    // ---------------------------------------------------------------------------------------
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (m_f) begin
                if (sat_inc(deb_cnt_q[i]) >= DebLim) begin
                    stable_d[i]  = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q      <= 2'b00;
            stable_prev_q <= 2'b00;
            deb_cnt_q     <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            deb_cnt_q     <= deb_cnt_d;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Press / hold / repeat FSM
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            act_q   <= 2'b00;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            tick_q  <= tick_d;
        end
    end

    assign rise     = stable_q & ~stable_prev_q;
    assign tick_inc = sat_inc(tick_q);

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        tick_d  = tick_q;
        fire    = 1'b0;
        if (stable_q == 2'b11) begin
            state_d = StLock;
            act_d   = 2'b00;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise == 2'b01 || rise == 2'b10) begin
                        state_d = StHold;
                        act_d   = rise;
                        tick_d  = '0;
                        fire    = 1'b1;
                    end
                end
                StHold: begin
                    if ((stable_q & act_q) == 2'b00) begin
                        state_d = StIdle;
                        act_d   = 2'b00;
                        tick_d  = '0;
                    end else if (m_f) begin
                        if (tick_inc >= DlyLim) begin
                            state_d = StRepeat;
                            tick_d  = '0;
                            fire    = 1'b1;
                        end else begin
                            tick_d = tick_inc;
                        end
                    end
                end
                StRepeat: begin
                    if ((stable_q & act_q) == 2'b00) begin
                        state_d = StIdle;
                        act_d   = 2'b00;
                        tick_d  = '0;
                    end else if (m_f) begin
                        if (tick_inc >= RptLim) begin
                            tick_d = '0;
                            fire   = 1'b1;
                        end else begin
                            tick_d = tick_inc;
                        end
                    end
                end
                StLock: begin
                    if (stable_q == 2'b00) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    act_d   = 2'b00;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // A requested step is dropped at the level bound; the FSM timing is unaffected.
    always_comb begin
        step_d = 2'b00;
        if (fire) begin
            if (act_d == 2'b10 && level_q < LvlMax) begin
                step_d = 2'b10;
            end else if (act_d == 2'b01 && level_q > LvlMin) begin
                step_d = 2'b01;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Level tracking, updated on the same edge that launches the step pulse
    // ---------------------------------------------------------------------------------------
    always_comb begin
        level_d = level_q;
        if (step_d[1]) begin
            level_d = level_q + 5'd1;
        end else if (step_d[0]) begin
            level_d = level_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q   <= 2'b00;
            level_q  <= LvlRst;
            at_min_q <= 1'b0;
            at_max_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            level_q  <= level_d;
            at_min_q <= (level_d == LvlMin);
            at_max_q <= (level_d == LvlMax);
        end
    end

    assign step   = step_q;
    assign level  = level_q;
    assign at_min = at_min_q;
    assign at_max = at_max_q;

endmodule

// File: tb/tb_speed_step_ctrl.sv
// Bench for speed_step_ctrl: directed scenarios plus random presses, scored against a
// press-level model that predicts step counts from the hold length in ms ticks.
module tb_speed_step_ctrl;

    localparam int DEB  = 3;
    localparam int DLY  = 5;
    localparam int RPT  = 2;
    localparam int LMIN = 9;
    localparam int LMAX = 26;
    localparam int LRST = 19;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       m_f     = 1'b0;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] step;
    logic [4:0] level;
    logic       at_min;
    logic       at_max;

    speed_step_ctrl #(
        .DEB_MS    (DEB),
        .RPT_DLY_MS(DLY),
        .RPT_MS    (RPT),
        .LVL_MIN   (LMIN),
        .LVL_MAX   (LMAX),
        .LVL_RST   (LRST)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_f    (m_f),
        .btn_raw(btn_raw),
        .step   (step),
        .level  (level),
        .at_min (at_min),
        .at_max (at_max)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_slow = 0;
    int n_fast = 0;
    int n_wide = 0;
    logic [1:0] step_prev = 2'b00;

    int exp_level = LRST;
    int exp_slow  = 0;
    int exp_fast  = 0;

    // Pulse monitor: counts step pulses and flags any pulse longer than a cycle or both bits.
    always @(negedge clk) begin
        if (rst) begin
            if (step[1]) n_slow++;
            if (step[0]) n_fast++;
            if (step == 2'b11 || (step != 2'b00 && step_prev != 2'b00)) n_wide++;
        end
        step_prev = step;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_level"}, 32'(level), 32'(exp_level));
        check({tag, "_slow"}, 32'(n_slow), 32'(exp_slow));
        check({tag, "_fast"}, 32'(n_fast), 32'(exp_fast));
        check({tag, "_at_min"}, 32'(at_min), 32'(exp_level == LMIN));
        check({tag, "_at_max"}, 32'(at_max), 32'(exp_level == LMAX));
    endtask

    // One ms tick, placed so a button change made on return is synchronized before the next.
    task automatic tick();
        repeat (3) @(negedge clk);
        m_f = 1'b1;
        @(negedge clk);
        m_f = 1'b0;
    endtask

    task automatic press(input logic [1:0] b, input int g);
        btn_raw = b;
        repeat (g) tick();
        btn_raw = 2'b00;
        repeat (5) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_level = LRST;
        tick();
    endtask

    // Raw press lasting g ticks: the debounced press lasts g ticks too, and steps are due at
    // debounced tick 0 and at DLY, DLY+RPT, ... up to and including tick g.
    function automatic void model(input int slower, input int g);
        if (g < DEB) return;
        for (int t = 0; t <= g; t++) begin
            if (t == 0 || (t >= DLY && ((t - DLY) % RPT) == 0)) begin
                if (slower != 0 && exp_level < LMAX) begin
                    exp_level++;
                    exp_slow++;
                end else if (slower == 0 && exp_level > LMIN) begin
                    exp_level--;
                    exp_fast++;
                end
            end
        end
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_step", 32'(step), 32'd0);
        check("rst_level", 32'(level), 32'(LRST));
        check("rst_at_min", 32'(at_min), 32'd0);
        check("rst_at_max", 32'(at_max), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        press(2'b01, 2);
        model(0, 2);
        check_all("glitch");

        press(2'b10, 3);
        model(1, 3);
        check_all("single");

        do_reset();
        press(2'b10, 12);
        model(1, 12);
        check_all("repeat12");

        do_reset();
        press(2'b01, 19);
        model(0, 19);
        check_all("down_to_10");
        press(2'b01, 9);
        model(0, 9);
        check_all("floor");

        do_reset();
        press(2'b10, 20);
        model(1, 20);
        check_all("ceiling");

        do_reset();
        btn_raw = 2'b11;
        repeat (4) tick();
        btn_raw = 2'b01;
        repeat (4) tick();
        check_all("lock_one");
        btn_raw = 2'b00;
        repeat (4) tick();
        check_all("lock_none");
        press(2'b10, 3);
        model(1, 3);
        check_all("post_lock");

        // Reset lands while the third slower pulse (tick 7, in REPEAT) is on the output.
        do_reset();
        btn_raw = 2'b10;
        repeat (DEB + 7) tick();
        model(1, 7);
        #1;
        rst = 1'b0;
        #1;
        check("async_step", 32'(step), 32'd0);
        check("async_level", 32'(level), 32'(LRST));
        exp_level = LRST;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;
        check("post_rst_quiet", 32'(n_slow), 32'(exp_slow));
        tick();
        btn_raw = 2'b00;
        repeat (5) tick();
        model(1, 3);
        check_all("post_rst_press");

        do_reset();
        for (int i = 0; i < 30; i++) begin
            int dir;
            int g;
            dir = int'($urandom_range(0, 1));
            g   = int'($urandom_range(0, 14));
            press((dir != 0) ? 2'b10 : 2'b01, g);
            model(dir, g);
            check_all($sformatf("rnd%0d", i));
        end

        check("pulse_shape", 32'(n_wide), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
